// File: rtl/walksat_controller.sv
// WalkSAT flip-iteration sequencer.
// Drives the datapath control bundle for one iteration at a time: clause
// request/load, pipelined break lookups, flip, push and FIFO drain.
// Bit 14 of the bundle is an unused pad, tied to 0.
module walksat_controller #(
  parameter int unsigned NSAT           = 3,
  parameter int unsigned PIPE_LAT       = 4,
  parameter int unsigned CT_LAT         = 2,
  parameter int unsigned VFS_LAT        = 2,
  parameter int unsigned MAX_FLIPS      = 1000000,
  parameter int unsigned FLIP_CNT_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      ucs_ready_i,
  input  logic                      ucs_empty_i,
  input  logic                      fifo_empty_i,
  output logic [14:0]               control_signal_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      sat_o,
  output logic [FLIP_CNT_WIDTH-1:0] flip_count_o
);

  localparam int unsigned CNT_MAX = (NSAT > VFS_LAT) ? NSAT : VFS_LAT;
  localparam int unsigned CNT_W   = (CNT_MAX < 3) ? 2 : $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAIT, S_LOAD, S_NEG, S_ISSUE,
    S_PIPE, S_SELECT, S_FLIP, S_PUSH, S_POP, S_DONE
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [FLIP_CNT_WIDTH-1:0] flip_nxt;
  logic                      busy_nxt, done_nxt, sat_nxt;

  // Literal tag pipeline: stage i holds the tag issued i cycles earlier.
  logic [PIPE_LAT:1]         tag_vld;
  logic [1:0]                tag_idx [PIPE_LAT:1];
  logic                      issue_vld;

  logic       cr_wr_en, vt_addr_src, vt_en, vt_wr_en, cflb_wr_en;
  logic       fifo_wr_en, fifo_rd_en, ucs_request;
  logic [1:0] att_src, vfs_wr_en, tb_wr_index;

  // State, counters and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      flip_count_o <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      sat_o        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      flip_count_o <= flip_nxt;
      busy_o       <= busy_nxt;
      done_o       <= done_nxt;
      sat_o        <= sat_nxt;
    end
  end

  // Shift the {valid, k} tags of issued literals down the lookup pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_vld <= '0;
      for (int i = 1; i <= int'(PIPE_LAT); i++) tag_idx[i] <= 2'b00;
    end else begin
      tag_vld[1] <= issue_vld;
      tag_idx[1] <= cnt[1:0];
      for (int i = 2; i <= int'(PIPE_LAT); i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  // Tag-driven fields: temporal buffer index and flip-selector write strobe.
  always_comb begin
    tb_wr_index = tag_vld[CT_LAT] ? tag_idx[CT_LAT] : 2'b11;
    vfs_wr_en   = tag_vld[PIPE_LAT] ? 2'(tag_idx[PIPE_LAT] + 2'd1) : 2'b00;
  end

  // Next-state and state-decoded control fields.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    flip_nxt    = flip_count_o;
    busy_nxt    = busy_o;
    done_nxt    = done_o;
    sat_nxt     = sat_o;
    issue_vld   = 1'b0;
    cr_wr_en    = 1'b0;
    att_src     = 2'b11;
    vt_addr_src = 1'b0;
    vt_en       = 1'b0;
    vt_wr_en    = 1'b0;
    cflb_wr_en  = 1'b0;
    fifo_wr_en  = 1'b0;
    fifo_rd_en  = 1'b0;
    ucs_request = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          flip_nxt  = '0;
          done_nxt  = 1'b0;
          sat_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        ucs_request = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (ucs_empty_i) begin
          done_nxt  = 1'b1;
          sat_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_DONE;
        end else if (ucs_ready_i) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        cr_wr_en  = 1'b1;
        state_nxt = S_NEG;
      end
      S_NEG: begin
        cflb_wr_en = 1'b1;
        cnt_nxt    = '0;
        state_nxt  = S_ISSUE;
      end
      S_ISSUE: begin
        att_src   = cnt[1:0];
        vt_en     = 1'b1;
        issue_vld = 1'b1;
        if (cnt == CNT_W'(NSAT - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_PIPE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_PIPE: begin
        if (tag_vld[PIPE_LAT] && (tag_idx[PIPE_LAT] == 2'(NSAT - 1))) begin
          cnt_nxt   = '0;
          state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        if (cnt == CNT_W'(VFS_LAT - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_FLIP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_FLIP: begin
        vt_addr_src = 1'b1;
        vt_en       = 1'b1;
        vt_wr_en    = 1'b1;
        state_nxt   = S_PUSH;
      end
      S_PUSH: begin
        fifo_wr_en = 1'b1;
        state_nxt  = S_POP;
      end
      S_POP: begin
        fifo_rd_en = ~fifo_empty_i;
        if (fifo_empty_i) begin
          flip_nxt = flip_count_o + FLIP_CNT_WIDTH'(1);
          if (flip_nxt == FLIP_CNT_WIDTH'(MAX_FLIPS)) begin
            done_nxt  = 1'b1;
            sat_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_REQ;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign control_signal_o = {1'b0, cr_wr_en, att_src, vt_addr_src, vt_en, vt_wr_en,
                             vfs_wr_en, cflb_wr_en, tb_wr_index, fifo_wr_en,
                             fifo_rd_en, ucs_request};

endmodule

// File: tb/tb_walksat_controller.sv
// Directed bench for walksat_controller: table-driven single iteration plus
// hand sequences for reset, FIFO drain, flip limit, stall and immediate SAT.
module tb_walksat_controller;

  logic        clk = 1'b0;
  logic        rst, start, ready, uempty, fempty;
  logic [14:0] ctl, ctl1;
  logic        busy, done, sat, busy1, done1, sat1;
  logic [31:0] fc, fc1;

  localparam logic [14:0] IDLE_CS = 15'b0_11_000_00_0_11_000;

  always #5 clk = ~clk;

  walksat_controller #(.MAX_FLIPS(3)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ucs_ready_i(ready),
    .ucs_empty_i(uempty), .fifo_empty_i(fempty), .control_signal_o(ctl),
    .busy_o(busy), .done_o(done), .sat_o(sat), .flip_count_o(fc));

  walksat_controller #(.MAX_FLIPS(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ucs_ready_i(ready),
    .ucs_empty_i(uempty), .fifo_empty_i(fempty), .control_signal_o(ctl1),
    .busy_o(busy1), .done_o(done1), .sat_o(sat1), .flip_count_o(fc1));

  int errors = 0;
  int checks = 0;
  int vwr_cnt = 0;
  int cr_cnt  = 0;

  // Count vt_wr_en and cr_wr_en pulses of the main instance.
  always @(negedge clk) begin
    if (ctl[8])  vwr_cnt++;
    if (ctl[13]) cr_cnt++;
  end

  typedef struct {
    logic        start;
    logic [14:0] cs;
    logic        busy;
    logic [31:0] fc;
  } vec_t;

  vec_t vec [18];

  function automatic logic [14:0] cs(input logic cr, input logic [1:0] att,
                                     input logic va, input logic ve, input logic vw,
                                     input logic [1:0] vfs, input logic cf,
                                     input logic [1:0] tb, input logic fw,
                                     input logic fr, input logic ur);
    return {1'b0, cr, att, va, ve, vw, vfs, cf, tb, fw, fr, ur};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd;
    int base;
    int crb;
    bit found;

    // Expected single iteration, started at cycle 0, ucs_ready=1, fifo empty.
    for (int i = 0; i < 18; i++) begin
      vec[i].start = 1'b0;
      vec[i].cs    = IDLE_CS;
      vec[i].busy  = 1'b1;
      vec[i].fc    = 32'd0;
    end
    vec[0].start = 1'b1;
    vec[0].busy  = 1'b0;
    vec[1].cs  = cs(0, 2'd3, 0, 0, 0, 2'd0, 0, 2'd3, 0, 0, 1);
    vec[3].cs  = cs(1, 2'd3, 0, 0, 0, 2'd0, 0, 2'd3, 0, 0, 0);
    vec[4].cs  = cs(0, 2'd3, 0, 0, 0, 2'd0, 1, 2'd3, 0, 0, 0);
    vec[5].cs  = cs(0, 2'd0, 0, 1, 0, 2'd0, 0, 2'd3, 0, 0, 0);
    vec[6].cs  = cs(0, 2'd1, 0, 1, 0, 2'd0, 0, 2'd3, 0, 0, 0);
    vec[7].cs  = cs(0, 2'd2, 0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0);
    vec[8].cs  = cs(0, 2'd3, 0, 0, 0, 2'd0, 0, 2'd1, 0, 0, 0);
    vec[9].cs  = cs(0, 2'd3, 0, 0, 0, 2'd1, 0, 2'd2, 0, 0, 0);
    vec[10].cs = cs(0, 2'd3, 0, 0, 0, 2'd2, 0, 2'd3, 0, 0, 0);
    vec[11].cs = cs(0, 2'd3, 0, 0, 0, 2'd3, 0, 2'd3, 0, 0, 0);
    vec[14].cs = cs(0, 2'd3, 1, 1, 1, 2'd0, 0, 2'd3, 0, 0, 0);
    vec[15].cs = cs(0, 2'd3, 0, 0, 0, 2'd0, 0, 2'd3, 1, 0, 0);
    vec[17].cs = cs(0, 2'd3, 0, 0, 0, 2'd0, 0, 2'd3, 0, 0, 1);
    vec[17].fc = 32'd1;

    // Reset held three cycles, then a run aborted by reset.
    rst = 1'b1; start = 1'b0; ready = 1'b0; uempty = 1'b0; fempty = 1'b1;
    repeat (3) next();
    rst = 1'b0;
    start = 1'b1;
    settle();
    chk("reset_ctl", ctl, IDLE_CS);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_fc", fc, 0);
    next();
    start = 1'b0;
    settle();
    chk("abort_req", ctl, cs(0, 2'd3, 0, 0, 0, 2'd0, 0, 2'd3, 0, 0, 1));
    next();
    rst = 1'b1;
    settle();
    next();
    settle();
    chk("abort_ctl", ctl, IDLE_CS);
    chk("abort_busy", busy, 0);
    chk("abort_fc", fc, 0);
    rst = 1'b0;
    next();

    // Single iteration, table driven.
    base = vwr_cnt;
    for (int i = 0; i < 18; i++) begin
      start = vec[i].start; ready = 1'b1; uempty = 1'b0; fempty = 1'b1;
      settle();
      chk($sformatf("iter_ctl_c%0d", i), ctl, vec[i].cs);
      chk($sformatf("iter_busy_c%0d", i), busy, vec[i].busy);
      chk($sformatf("iter_fc_c%0d", i), fc, vec[i].fc);
      chk($sformatf("iter_done_c%0d", i), done, 0);
      if (i == 17) begin
        chk("max1_done", done1, 1);
        chk("max1_sat", sat1, 0);
        chk("max1_fc", fc1, 1);
        chk("max1_busy", busy1, 0);
      end
      next();
    end
    start = 1'b0;

    // FIFO drain: four non-empty cycles in S_POP.
    found = 1'b0;
    for (int j = 0; j < 40 && !found; j++) begin
      settle();
      if (ctl[2]) found = 1'b1;
      else next();
    end
    chk("push_seen", found, 1);
    next();
    fempty = 1'b0;
    rd = 0;
    for (int j = 0; j < 4; j++) begin
      settle();
      if (ctl[1]) rd++;
      next();
    end
    fempty = 1'b1;
    settle();
    chk("drain_rd_off", ctl[1], 0);
    chk("drain_rd_count", rd, 4);
    next();
    settle();
    chk("drain_req", ctl[0], 1);
    chk("drain_fc", fc, 2);

    // Flip limit reached on the third flip.
    found = 1'b0;
    for (int j = 0; j < 40 && !found; j++) begin
      next();
      settle();
      if (done) found = 1'b1;
    end
    chk("limit_seen", found, 1);
    chk("limit_sat", sat, 0);
    chk("limit_fc", fc, 3);
    chk("limit_busy", busy, 0);
    chk("limit_flips", vwr_cnt - base, 3);
    next();
    settle();
    chk("limit_done_held", done, 1);
    start = 1'b1;
    next();
    start = 1'b0;
    settle();
    chk("restart_fc", fc, 0);
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_req", ctl, cs(0, 2'd3, 0, 0, 0, 2'd0, 0, 2'd3, 0, 0, 1));

    // Stall in S_WAIT with start pulses that must be ignored.
    ready = 1'b0;
    next();
    crb = cr_cnt;
    for (int j = 0; j < 10; j++) begin
      start = (j % 3 == 0);
      settle();
      chk($sformatf("stall_ctl_%0d", j), ctl, IDLE_CS);
      chk($sformatf("stall_busy_%0d", j), busy, 1);
      next();
    end
    start = 1'b0;
    // ucs_empty wins over ucs_ready.
    uempty = 1'b1; ready = 1'b1;
    next();
    settle();
    chk("empty_prio_done", done, 1);
    chk("empty_prio_sat", sat, 1);
    chk("empty_prio_fc", fc, 0);
    chk("empty_prio_ctl", ctl, IDLE_CS);
    next();
    chk("stall_no_load", cr_cnt - crb, 0);

    // Immediate SAT from a fresh start.
    crb = cr_cnt;
    start = 1'b1;
    next();
    start = 1'b0;
    settle();
    chk("sat_req_c1", ctl, cs(0, 2'd3, 0, 0, 0, 2'd0, 0, 2'd3, 0, 0, 1));
    chk("sat_done_c1", done, 0);
    next();
    settle();
    chk("sat_wait_c2", ctl, IDLE_CS);
    next();
    settle();
    chk("sat_done_c3", done, 1);
    chk("sat_sat_c3", sat, 1);
    chk("sat_fc_c3", fc, 0);
    next();
    chk("sat_no_load", cr_cnt - crb, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
